exc_commit_ctrl: RTL and testbench



---
 rtl/exc_commit_pkg.sv | 23 ++
 rtl/exc_perf_cnt.sv | 21 ++
 rtl/exc_commit_ctrl.sv | 125 ++++++++++++
 tb/tb_exc_commit_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_commit_pkg.sv
// Shared types and constants for the writeback exception/interrupt commit controller.
package exc_commit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRAP  = 2'd1,
    REDIR = 2'd2
  } exc_state_e;

  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [5:0] ECODE_SYS = 6'h0B;

  typedef struct packed {
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic [31:0] pc;
    logic [31:0] vaddr;
    logic        is_ertn;
  } exc_payload_t;

endpackage

// File: rtl/exc_perf_cnt.sv
// 32-bit wrapping event counter with synchronous reset and increment enable.
module exc_perf_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [31:0] cnt
);

  logic [31:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 32'h0;
    end else if (en) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/exc_commit_ctrl.sv
// WB-side exception/interrupt/ERTN commit controller driving the CSR trap interface and fetch redirect.
// Optional performance counters are built when EXC_COMMIT_PERF_EN is defined.
module exc_commit_ctrl
  import exc_commit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_valid,
  output logic        ws_ready,
  input  logic [31:0] ws_pc,
  input  logic        ws_exc,
  input  logic [5:0]  ws_ecode,
  input  logic [8:0]  ws_esubcode,
  input  logic [31:0] ws_vaddr,
  input  logic        ws_ertn,
  output logic        commit_ok,
  input  logic        csr_has_int,
  input  logic [31:0] csr_ex_entry,
  input  logic [31:0] csr_era,
  output logic        wb_ex,
  output logic        ertn_flush,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_vaddr,
  output logic        pipe_flush,
  output logic        redir_valid,
  output logic [31:0] redir_pc,
  input  logic        redir_ready,
  output logic [31:0] retire_cnt,
  output logic [31:0] trap_cnt
);

  exc_state_e   state_q, state_d;
  exc_payload_t pay_q, pay_d;
  logic [31:0]  redir_pc_q, redir_pc_d;
  logic         event_hit;

  assign event_hit = csr_has_int | ws_exc | ws_ertn;

  always_comb begin
    state_d     = state_q;
    pay_d       = pay_q;
    redir_pc_d  = redir_pc_q;
    ws_ready    = 1'b0;
    commit_ok   = 1'b0;
    wb_ex       = 1'b0;
    ertn_flush  = 1'b0;
    pipe_flush  = 1'b0;
    redir_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        ws_ready  = 1'b1;
        commit_ok = ws_valid & ~event_hit;
        if (ws_valid && event_hit) begin
          state_d          = TRAP;
          pay_d.pc         = ws_pc;
          pay_d.ecode      = ws_ecode;
          pay_d.esubcode   = ws_esubcode;
          pay_d.vaddr      = ws_vaddr;
          // Interrupt outranks exception, which outranks ERTN.
          pay_d.is_ertn    = ~csr_has_int & ~ws_exc;
          if (csr_has_int) begin
            pay_d.ecode    = ECODE_INT;
            pay_d.esubcode = 9'h0;
            pay_d.vaddr    = 32'h0;
          end
        end
      end
      TRAP: begin
        wb_ex      = ~pay_q.is_ertn;
        ertn_flush = pay_q.is_ertn;
        pipe_flush = 1'b1;
        redir_pc_d = pay_q.is_ertn ? csr_era : csr_ex_entry;
        state_d    = REDIR;
      end
      REDIR: begin
        redir_valid = 1'b1;
        pipe_flush  = 1'b1;
        if (redir_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pay_q      <= '0;
      redir_pc_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      pay_q      <= pay_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  assign wb_ecode    = pay_q.ecode;
  assign wb_esubcode = pay_q.esubcode;
  assign wb_pc       = pay_q.pc;
  assign wb_vaddr    = pay_q.vaddr;
  assign redir_pc    = redir_pc_q;

`ifdef EXC_COMMIT_PERF_EN
  exc_perf_cnt u_retire_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (commit_ok),
    .cnt   (retire_cnt)
  );

  exc_perf_cnt u_trap_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (wb_ex),
    .cnt   (trap_cnt)
  );
`else
  assign retire_cnt = 32'h0;
  assign trap_cnt   = 32'h0;
`endif

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Directed self-checking bench for exc_commit_ctrl; counter checks follow EXC_COMMIT_PERF_EN.
module tb_exc_commit_ctrl;

`ifdef EXC_COMMIT_PERF_EN
  localparam bit Perf = 1'b1;
`else
  localparam bit Perf = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ws_valid, ws_ready, ws_exc, ws_ertn, commit_ok, csr_has_int;
  logic [31:0] ws_pc, ws_vaddr, csr_ex_entry, csr_era;
  logic [5:0]  ws_ecode, wb_ecode;
  logic [8:0]  ws_esubcode, wb_esubcode;
  logic        wb_ex, ertn_flush, pipe_flush, redir_valid, redir_ready;
  logic [31:0] wb_pc, wb_vaddr, redir_pc, retire_cnt, trap_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  exc_commit_ctrl u_dut (
    .clk          (clk),
    .reset        (reset),
    .ws_valid     (ws_valid),
    .ws_ready     (ws_ready),
    .ws_pc        (ws_pc),
    .ws_exc       (ws_exc),
    .ws_ecode     (ws_ecode),
    .ws_esubcode  (ws_esubcode),
    .ws_vaddr     (ws_vaddr),
    .ws_ertn      (ws_ertn),
    .commit_ok    (commit_ok),
    .csr_has_int  (csr_has_int),
    .csr_ex_entry (csr_ex_entry),
    .csr_era      (csr_era),
    .wb_ex        (wb_ex),
    .ertn_flush   (ertn_flush),
    .wb_ecode     (wb_ecode),
    .wb_esubcode  (wb_esubcode),
    .wb_pc        (wb_pc),
    .wb_vaddr     (wb_vaddr),
    .pipe_flush   (pipe_flush),
    .redir_valid  (redir_valid),
    .redir_pc     (redir_pc),
    .redir_ready  (redir_ready),
    .retire_cnt   (retire_cnt),
    .trap_cnt     (trap_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ws();
    ws_valid    = 1'b0;
    ws_exc      = 1'b0;
    ws_ertn     = 1'b0;
    csr_has_int = 1'b0;
    ws_ecode    = 6'h0;
    ws_esubcode = 9'h0;
    ws_vaddr    = 32'h0;
    ws_pc       = 32'h0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ws_ready"}, {31'h0, ws_ready}, 32'h1);
    check({tag, "_wb_ex"}, {31'h0, wb_ex}, 32'h0);
    check({tag, "_ertn_flush"}, {31'h0, ertn_flush}, 32'h0);
    check({tag, "_pipe_flush"}, {31'h0, pipe_flush}, 32'h0);
    check({tag, "_redir_valid"}, {31'h0, redir_valid}, 32'h0);
    check({tag, "_commit_ok"}, {31'h0, commit_ok}, 32'h0);
    check({tag, "_wb_ecode"}, {26'h0, wb_ecode}, 32'h0);
    check({tag, "_wb_esubcode"}, {23'h0, wb_esubcode}, 32'h0);
    check({tag, "_wb_pc"}, wb_pc, 32'h0);
    check({tag, "_wb_vaddr"}, wb_vaddr, 32'h0);
    check({tag, "_redir_pc"}, redir_pc, 32'h0);
    check({tag, "_retire_cnt"}, retire_cnt, 32'h0);
    check({tag, "_trap_cnt"}, trap_cnt, 32'h0);
  endtask

  initial begin
    reset        = 1'b1;
    redir_ready  = 1'b0;
    csr_ex_entry = 32'h1C00_8000;
    csr_era      = 32'h1C00_0204;
    clear_ws();
    step();
    step();
    reset = 1'b0;
    #1;
    check_reset_vals("rst");

    // Plain commit
    ws_valid = 1'b1;
    ws_pc    = 32'h1C00_0000;
    #1;
    check("plain_commit_ok", {31'h0, commit_ok}, 32'h1);
    check("plain_ws_ready", {31'h0, ws_ready}, 32'h1);
    step();
    clear_ws();
    check("plain_retire_cnt", retire_cnt, Perf ? 32'd1 : 32'd0);
    check("plain_no_flush", {31'h0, pipe_flush}, 32'h0);

    // SYSCALL
    redir_ready = 1'b1;
    ws_valid    = 1'b1;
    ws_exc      = 1'b1;
    ws_ecode    = 6'h0B;
    ws_pc       = 32'h1C00_0100;
    #1;
    check("sys_commit_ok", {31'h0, commit_ok}, 32'h0);
    step();
    clear_ws();
    check("sys_wb_ex", {31'h0, wb_ex}, 32'h1);
    check("sys_ertn", {31'h0, ertn_flush}, 32'h0);
    check("sys_ecode", {26'h0, wb_ecode}, 32'h0B);
    check("sys_pc", wb_pc, 32'h1C00_0100);
    check("sys_flush", {31'h0, pipe_flush}, 32'h1);
    check("sys_ws_ready_t1", {31'h0, ws_ready}, 32'h0);
    check("sys_rv_t1", {31'h0, redir_valid}, 32'h0);
    step();
    check("sys_rv_t2", {31'h0, redir_valid}, 32'h1);
    check("sys_redir_pc", redir_pc, 32'h1C00_8000);
    check("sys_wb_ex_t2", {31'h0, wb_ex}, 32'h0);
    step();
    check("sys_idle_ready", {31'h0, ws_ready}, 32'h1);
    check("sys_idle_rv", {31'h0, redir_valid}, 32'h0);
    check("sys_trap_cnt", trap_cnt, Perf ? 32'd1 : 32'd0);

    // Interrupt beats exception
    ws_valid    = 1'b1;
    ws_exc      = 1'b1;
    csr_has_int = 1'b1;
    ws_ecode    = 6'h09;
    ws_esubcode = 9'h1;
    ws_vaddr    = 32'hDEAD_0000;
    ws_pc       = 32'h1C00_0300;
    #1;
    check("int_commit_ok", {31'h0, commit_ok}, 32'h0);
    step();
    clear_ws();
    check("int_wb_ex", {31'h0, wb_ex}, 32'h1);
    check("int_ecode", {26'h0, wb_ecode}, 32'h00);
    check("int_esub", {23'h0, wb_esubcode}, 32'h0);
    check("int_vaddr", wb_vaddr, 32'h0);
    check("int_pc", wb_pc, 32'h1C00_0300);
    step();
    step();
    check("int_trap_cnt", trap_cnt, Perf ? 32'd2 : 32'd0);

    // ERTN
    ws_valid = 1'b1;
    ws_ertn  = 1'b1;
    ws_pc    = 32'h1C00_0400;
    step();
    clear_ws();
    check("ertn_flush", {31'h0, ertn_flush}, 32'h1);
    check("ertn_no_wb_ex", {31'h0, wb_ex}, 32'h0);
    step();
    check("ertn_redir_pc", redir_pc, 32'h1C00_0204);
    check("ertn_rv", {31'h0, redir_valid}, 32'h1);
    step();
    check("ertn_trap_cnt", trap_cnt, Perf ? 32'd2 : 32'd0);

    // ERTN together with an exception is treated as the exception
    ws_valid = 1'b1;
    ws_ertn  = 1'b1;
    ws_exc   = 1'b1;
    ws_ecode = 6'h08;
    step();
    clear_ws();
    check("exertn_wb_ex", {31'h0, wb_ex}, 32'h1);
    check("exertn_flush", {31'h0, ertn_flush}, 32'h0);
    step();
    check("exertn_redir_pc", redir_pc, 32'h1C00_8000);
    step();

    // Backpressure on redirect
    redir_ready  = 1'b0;
    csr_ex_entry = 32'h1C00_9000;
    ws_valid     = 1'b1;
    ws_exc       = 1'b1;
    ws_ecode     = 6'h08;
    ws_pc        = 32'h1C00_0500;
    step();
    clear_ws();
    step();
    csr_ex_entry = 32'h0BAD_0BAD;
    for (int i = 0; i < 5; i++) begin
      check("bp_rv", {31'h0, redir_valid}, 32'h1);
      check("bp_redir_pc", redir_pc, 32'h1C00_9000);
      check("bp_ws_ready", {31'h0, ws_ready}, 32'h0);
      step();
    end
    redir_ready = 1'b1;
    #1;
    check("bp_rv_hs", {31'h0, redir_valid}, 32'h1);
    step();
    redir_ready = 1'b0;
    check("bp_idle_ready", {31'h0, ws_ready}, 32'h1);
    check("bp_idle_rv", {31'h0, redir_valid}, 32'h0);

    // Reset while waiting in REDIR
    ws_valid = 1'b1;
    ws_exc   = 1'b1;
    ws_ecode = 6'h0B;
    ws_pc    = 32'h1C00_0600;
    step();
    clear_ws();
    step();
    check("rr_rv", {31'h0, redir_valid}, 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_vals("rr");

`ifdef EXC_COMMIT_PERF_EN
    // Counter wrap
    force u_dut.u_retire_cnt.cnt_q = 32'hFFFF_FFFF;
    #1;
    release u_dut.u_retire_cnt.cnt_q;
    check("wrap_pre", retire_cnt, 32'hFFFF_FFFF);
    ws_valid = 1'b1;
    step();
    clear_ws();
    check("wrap_post", retire_cnt, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
